// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - two-stage radix-2 DIT complex butterfly, A' = A + B*W, B' = A - B*W
// Optional BUTTERFLY_SAT_EN: saturate on narrowing instead of two's-complement wrap.
module butterfly_pipe #(
   parameter int DATA_WIDTH = 21,
   parameter int FRAC_BITS  = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_i,
   input  logic [0:1][DATA_WIDTH-1:0] twid_i,
   input  logic [0:1][DATA_WIDTH-1:0] a_i,
   input  logic [0:1][DATA_WIDTH-1:0] b_i,
   output logic                       valid_o,
   output logic [0:1][DATA_WIDTH-1:0] a_o,
   output logic [0:1][DATA_WIDTH-1:0] b_o
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int RW = PW + 2;
   localparam logic signed [RW-1:0] RND_C =
      {{(RW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`ifdef BUTTERFLY_SAT_EN
   localparam logic signed [RW-1:0] MAX_V = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

   logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
   logic signed [DATA_WIDTH-1:0] a1_re, a1_im;
   logic                         valid1;

   logic signed [RW-1:0]         re_full, im_full, re_rnd, im_rnd;
   logic signed [DATA_WIDTH-1:0] b_rot_re, b_rot_im;
   logic signed [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;

   function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [RW-1:0] x);
`ifdef BUTTERFLY_SAT_EN
      if (x > MAX_V)
         return MAX_V[DATA_WIDTH-1:0];
      else if (x < MIN_V)
         return MIN_V[DATA_WIDTH-1:0];
      else
         return x[DATA_WIDTH-1:0];
`else
      return x[DATA_WIDTH-1:0];
`endif
   endfunction

   // Stage 1: partial products and A alignment; data loads every cycle, valid only qualifies.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_rr   <= '0;
         p_ii   <= '0;
         p_ri   <= '0;
         p_ir   <= '0;
         a1_re  <= '0;
         a1_im  <= '0;
         valid1 <= 1'b0;
      end else begin
         p_rr   <= $signed(b_i[0]) * $signed(twid_i[0]);
         p_ii   <= $signed(b_i[1]) * $signed(twid_i[1]);
         p_ri   <= $signed(b_i[0]) * $signed(twid_i[1]);
         p_ir   <= $signed(b_i[1]) * $signed(twid_i[0]);
         a1_re  <= $signed(a_i[0]);
         a1_im  <= $signed(a_i[1]);
         valid1 <= valid_i;
      end
   end

   // Full-precision rotation, round half toward +inf, then narrow to data width.
   always_comb begin
      re_full  = p_rr - p_ii;
      im_full  = p_ri + p_ir;
      re_rnd   = (re_full + RND_C) >>> FRAC_BITS;
      im_rnd   = (im_full + RND_C) >>> FRAC_BITS;
      b_rot_re = narrow(re_rnd);
      b_rot_im = narrow(im_rnd);
      sum_re   = a1_re + b_rot_re;
      sum_im   = a1_im + b_rot_im;
      dif_re   = a1_re - b_rot_re;
      dif_im   = a1_im - b_rot_im;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_o     <= '0;
         b_o     <= '0;
         valid_o <= 1'b0;
      end else begin
         a_o[0]  <= narrow(sum_re);
         a_o[1]  <= narrow(sum_im);
         b_o[0]  <= narrow(dif_re);
         b_o[1]  <= narrow(dif_im);
         valid_o <= valid1;
      end
   end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - directed and randomized checks of butterfly_pipe against an arithmetic model
module tb_butterfly_pipe;

   localparam int     DW   = 21;
   localparam longint HALF = longint'(1) << (DW - 1);
   localparam longint FULL = longint'(1) << DW;
   localparam longint ONE  = 32768;

   typedef struct {
      longint rr, ri, aor, aoi, bor, boi;
   } res_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                valid_i;
   logic [0:1][DW-1:0]  twid_i, a_i, b_i;
   logic                valid_o;
   logic [0:1][DW-1:0]  a_o, b_o;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(15)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .twid_i  (twid_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (valid_o),
      .a_o     (a_o),
      .b_o     (b_o)
   );

   function automatic longint sx(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic longint fit(input longint x);
      longint m;
`ifdef BUTTERFLY_SAT_EN
      if (x > HALF - 1) return HALF - 1;
      if (x < -HALF) return -HALF;
      return x;
`else
      m = x % FULL;
      if (m >= HALF) m = m - FULL;
      else if (m < -HALF) m = m + FULL;
      return m;
`endif
   endfunction

   // floor((x + ONE/2) / ONE) using division, with explicit floor for negatives
   function automatic longint rnd(input longint x);
      longint t, q;
      t = x + ONE / 2;
      q = t / ONE;
      if (t < 0 && (t % ONE) != 0) q = q - 1;
      return q;
   endfunction

   function automatic res_t model(input longint ar, ai, br, bi, wr, wi);
      res_t r;
      r.rr  = fit(rnd(br * wr - bi * wi));
      r.ri  = fit(rnd(br * wi + bi * wr));
      r.aor = fit(ar + r.rr);
      r.aoi = fit(ai + r.ri);
      r.bor = fit(ar - r.rr);
      r.boi = fit(ai - r.ri);
      return r;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input longint ar, ai, br, bi, wr, wi);
      valid_i   = v;
      a_i[0]    = DW'(ar);
      a_i[1]    = DW'(ai);
      b_i[0]    = DW'(br);
      b_i[1]    = DW'(bi);
      twid_i[0] = DW'(wr);
      twid_i[1] = DW'(wi);
   endtask

   task automatic chk_rot(input string tag, input res_t e);
      chk({tag, ".b_rot_re"}, sx(dut.b_rot_re), e.rr);
      chk({tag, ".b_rot_im"}, sx(dut.b_rot_im), e.ri);
   endtask

   task automatic chk_out(input string tag, input res_t e);
      chk({tag, ".valid_o"}, longint'(valid_o), 1);
      chk({tag, ".a_re"}, sx(a_o[0]), e.aor);
      chk({tag, ".a_im"}, sx(a_o[1]), e.aoi);
      chk({tag, ".b_re"}, sx(b_o[0]), e.bor);
      chk({tag, ".b_im"}, sx(b_o[1]), e.boi);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid_o"}, longint'(valid_o), 0);
      chk({tag, ".a_re"}, sx(a_o[0]), 0);
      chk({tag, ".a_im"}, sx(a_o[1]), 0);
      chk({tag, ".b_re"}, sx(b_o[0]), 0);
      chk({tag, ".b_im"}, sx(b_o[1]), 0);
   endtask

   task automatic run_vec(input string tag, input longint ar, ai, br, bi, wr, wi);
      res_t e;
      e = model(ar, ai, br, bi, wr, wi);
      drive(1'b1, ar, ai, br, bi, wr, wi);
      tick();
      chk_rot(tag, e);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_out(tag, e);
   endtask

   initial begin
      res_t   e2, e3, e;
      res_t   exp_q[$];
      longint ar, ai, br, bi;

      // reset held 3 cycles with live-looking input
      rst = 1'b1;
      drive(1'b1, 5000, -7000, 9000, 123, 30274, -12540);
      tick();
      tick();
      tick();
      chk_zero("reset");
      chk_rot("reset", '{0, 0, 0, 0, 0, 0});

      // first valid after release appears exactly two cycles later
      e2 = model(16384, 0, 8192, 8192, 30274, -12540);
      rst = 1'b0;
      drive(1'b1, 16384, 0, 8192, 8192, 30274, -12540);
      tick();
      chk("first.valid_o_1cyc", longint'(valid_o), 0);
      chk_rot("vec_half", e2);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_out("vec_half", e2);
      tick();
      chk("vec_half.valid_drop", longint'(valid_o), 0);

      run_vec("vec_quarter", 32768, 0, 0, -16384, 30274, -12540);
      run_vec("overflow", 1048575, 0, 32768, 0, 32767, 0);

      // back-to-back samples
      e3 = model(32768, 0, 0, -16384, 30274, -12540);
      drive(1'b1, 16384, 0, 8192, 8192, 30274, -12540);
      tick();
      chk_rot("b2b0", e2);
      drive(1'b1, 32768, 0, 0, -16384, 30274, -12540);
      tick();
      chk_out("b2b0", e2);
      chk_rot("b2b1", e3);
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_out("b2b1", e3);
      tick();
      chk("b2b.valid_end", longint'(valid_o), 0);

      // reset mid-stream drops the in-flight sample
      drive(1'b1, 16384, 0, 8192, 8192, 30274, -12540);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0, 0);
      chk_zero("midreset");
      tick();
      chk_zero("midreset_next");

      // unity twiddle, random stream at full throughput
      for (int i = 0; i <= 100; i++) begin
         if (i < 100) begin
            ar = longint'($urandom_range(0, 1048575)) - 524288;
            ai = longint'($urandom_range(0, 1048575)) - 524288;
            br = longint'($urandom_range(0, 1048575)) - 524288;
            bi = longint'($urandom_range(0, 1048575)) - 524288;
            e  = model(ar, ai, br, bi, ONE, 0);
            e.aor = ar + br;
            e.aoi = ai + bi;
            e.bor = ar - br;
            e.boi = ai - bi;
            exp_q.push_back(e);
            drive(1'b1, ar, ai, br, bi, ONE, 0);
         end else begin
            drive(1'b0, 0, 0, 0, 0, 0, 0);
         end
         tick();
         if (i >= 1) begin
            if (exp_q.size() == 0) begin
               chk("unity.queue_empty", 0, 1);
            end else begin
               chk_out("unity", exp_q.pop_front());
            end
         end
      end
      tick();
      chk("unity.valid_end", longint'(valid_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
